pulse_width_encoder: RTL and testbench
======================================

Name: pulse_width_encoder

Overview:
Transmit end of the pulse-width temporal encoding consumed by the team's race-logic operators, e.g. not_equal in pulse-width mode. Accepts binary onset values over a valid/ready handshake and emits one fixed-width pulse per gamma cycle at the encoded time. Also drives the per-gamma-cycle reset that downstream operators take on their rst input. Two instances plus a not_equal form the standard operator test harness.

Parameters:
GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (>= PULSE_WIDTH+2)
PULSE_WIDTH, 8, pulse length in aclk cycles
VAL_W, $clog2(GAMMA_CYCLE_WIDTH), width of in_value

Ports:
aclk  input  1  clock
grst  input  1  global reset, asynchronous, active-high
in_valid  input  1  producer has a value
in_ready  output  1  encoder accepts this cycle
in_value  input  VAL_W  onset value
in_null  input  1  encode "no event" (no pulse)
y  output  1  temporal output, idle 0
gamma_rst  output  1  per-gamma reset to downstream, high in slot 0
overflow  output  1  one-cycle strobe: accepted value was clamped
underrun  output  1  one-cycle strobe: gamma boundary with nothing queued

Behaviour:
- Gamma counter cnt: 0..GAMMA_CYCLE_WIDTH-1, free-running from grst release; at_last = (cnt == GAMMA_CYCLE_WIDTH-1); wraps to 0.
- gamma_rst registered; high exactly when cnt == 0 (1 cycle per gamma).
- Two slots: next (holding) and cur (active), each {vld, null, value}.
- in_ready = !grst & (!next.vld | at_last). Accept = in_valid & in_ready.
- MAXV = GAMMA_CYCLE_WIDTH-1-PULSE_WIDTH (7 at defaults). Accepted value > MAXV: stored as MAXV, overflow=1 next cycle. Null inputs are never clamped.
- At at_last: if next.vld, cur<=next and next<=accepted input (if any); else if accept, cur<=input (bypass); else cur<=null, underrun=1 next cycle.
- Accept when !at_last: next<=input. Producer must hold in_valid until accepted.
- Pulse: y=1 in cycles where cnt is in [value+1, value+PULSE_WIDTH] and cur.vld & !cur.null. y is registered and aligned with cnt, computed from next-state cnt. Exactly PULSE_WIDTH cycles; never crosses a gamma boundary; never overlaps gamma_rst.
- First gamma after reset: cur empty; y stays 0; no underrun strobe for it.
- Reset values (async on grst): cnt=0, slots empty, y=0, gamma_rst=1, overflow=0, underrun=0. Reset mid-pulse drops y immediately; queued values are discarded.

Optional Feature:
PW_ENC_FALLING_EN. Defined: y idles 1 and the pulse is driven 0, matching falling-edge encoding; reset value of y is 1. Undefined: polarity as above. Timing is identical in both builds.

Decomposition:
- Package temporal_pkg: GAMMA_CYCLE_WIDTH and PULSE_WIDTH defaults, MAXV function, typedef enc_slot_t {vld, null, value}.
- Sub-module gamma_counter: counter plus at_last and gamma_rst generation. Shared later with a pulse-width decoder.

Test Plan:
(All at defaults: GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8.)
1. Release grst, no input for 3 gammas -> gamma_rst high at cnt 0 every 16 cycles; y=0 throughout; underrun strobe after gammas 2 and 3 (none after gamma 1).
2. Send value 1 during gamma 0 -> in gamma 1, y=1 for cnt 2..9 (8 cycles); no overflow.
3. Send value 3, then value 0 held valid -> second send accepted only at at_last, in_ready=0 in between; gamma 1 pulse at cnt 4..11, gamma 2 pulse at cnt 1..8.
4. Send value 12 -> overflow strobe 1 cycle after accept; pulse at cnt 8..15; gamma_rst still at cnt 0 of next gamma.
5. Send in_null=1 -> no pulse that gamma and no underrun; compile with PW_ENC_FALLING_EN, repeat test 2 -> y=0 for cnt 2..9, else 1.
6. Assert grst at cnt 5 of a value-1 pulse -> y=0 immediately, gamma_rst=1; after release, queue empty and first gamma silent.

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared defaults, slot type and clamp limit for the race-logic temporal encoders/decoders.
package temporal_pkg;

   localparam int unsigned GAMMA_CYCLE_WIDTH_DEF = 16;
   localparam int unsigned PULSE_WIDTH_DEF       = 8;
   // Slot value field is fixed-width; supports gamma cycles up to 256 aclk cycles.
   localparam int unsigned SLOT_VAL_W            = 8;

   typedef struct packed {
      logic                  vld;
      logic                  null_ev;
      logic [SLOT_VAL_W-1:0] value;
   } enc_slot_t;

   // Largest onset whose pulse still ends inside the gamma cycle.
   function automatic int unsigned maxv(input int unsigned gamma_w, input int unsigned pulse_w);
      return gamma_w - 1 - pulse_w;
   endfunction

endpackage

// File: rtl/pulse_width_encoder_gamma_counter.sv
// Free-running gamma-cycle counter with last-slot flag and registered per-gamma reset.
module gamma_counter
   import temporal_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
   parameter int unsigned CNT_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic             aclk,
   input  logic             grst,
   output logic [CNT_W-1:0] cnt,
   output logic             at_last,
   output logic             gamma_rst
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 1);

   logic [CNT_W-1:0] cnt_n;

   always_comb begin
      at_last = (cnt == LAST);
      cnt_n   = at_last ? '0 : cnt + CNT_W'(1);
   end

   // gamma_rst is registered from the next count so it lines up with cnt == 0.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         cnt       <= '0;
         gamma_rst <= 1'b1;
      end else begin
         cnt       <= cnt_n;
         gamma_rst <= (cnt_n == '0);
      end
   end

endmodule

// File: rtl/pulse_width_encoder.sv
// Pulse-width temporal encoder: one fixed-width pulse per gamma cycle at the onset value.
// Build option PW_ENC_FALLING_EN: y idles high and the pulse is driven low.
module pulse_width_encoder
   import temporal_pkg::*;
#(
   parameter int unsigned GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEF,
   parameter int unsigned PULSE_WIDTH       = PULSE_WIDTH_DEF,
   parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic             aclk,
   input  logic             grst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VAL_W-1:0] in_value,
   input  logic             in_null,
   output logic             y,
   output logic             gamma_rst,
   output logic             overflow,
   output logic             underrun
);

   localparam logic [VAL_W-1:0]      MAXV_V = VAL_W'(maxv(GAMMA_CYCLE_WIDTH, PULSE_WIDTH));
   localparam logic [SLOT_VAL_W-1:0] PW_S   = SLOT_VAL_W'(PULSE_WIDTH);
`ifdef PW_ENC_FALLING_EN
   localparam logic Y_IDLE = 1'b1;
`else
   localparam logic Y_IDLE = 1'b0;
`endif

   logic [VAL_W-1:0]      cnt;
   logic [VAL_W-1:0]      cnt_next;
   logic [SLOT_VAL_W-1:0] cnt_ext;
   logic                  at_last;
   enc_slot_t             next_q, next_n, cur_q, cur_n, in_slot;
   logic                  primed_q, primed_n;
   logic                  accept, pulse_n, underrun_n, overflow_n;

   gamma_counter #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
      .CNT_W            (VAL_W)
   ) u_gamma (
      .aclk     (aclk),
      .grst     (grst),
      .cnt      (cnt),
      .at_last  (at_last),
      .gamma_rst(gamma_rst)
   );

   always_comb begin
      in_ready   = !grst && (!next_q.vld || at_last);
      accept     = in_valid && in_ready;
      overflow_n = accept && !in_null && (in_value > MAXV_V);

      in_slot.vld     = 1'b1;
      in_slot.null_ev = in_null;
      in_slot.value   = '0;
      if (!in_null) begin
         in_slot.value = SLOT_VAL_W'((in_value > MAXV_V) ? MAXV_V : in_value);
      end

      next_n     = next_q;
      cur_n      = cur_q;
      primed_n   = primed_q;
      underrun_n = 1'b0;
      // At the boundary the holding slot is promoted; an empty holding slot lets
      // an input arriving in the last slot bypass straight into the active slot.
      if (at_last) begin
         primed_n = 1'b1;
         if (next_q.vld) begin
            cur_n  = next_q;
            next_n = accept ? in_slot : '0;
         end else if (accept) begin
            cur_n = in_slot;
         end else begin
            cur_n      = '0;
            underrun_n = primed_q;
         end
      end else if (accept) begin
         next_n = in_slot;
      end

      cnt_next = at_last ? '0 : cnt + VAL_W'(1);
      cnt_ext  = SLOT_VAL_W'(cnt_next);
      pulse_n  = cur_n.vld && !cur_n.null_ev &&
                 (cnt_ext > cur_n.value) && (cnt_ext <= cur_n.value + PW_S);
   end

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         next_q   <= '0;
         cur_q    <= '0;
         primed_q <= 1'b0;
         y        <= Y_IDLE;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         next_q   <= next_n;
         cur_q    <= cur_n;
         primed_q <= primed_n;
         y        <= pulse_n ^ Y_IDLE;
         overflow <= overflow_n;
         underrun <= underrun_n;
      end
   end

endmodule

// File: tb/tb_pulse_width_encoder.sv
// Self-checking bench for pulse_width_encoder: directed steps plus random traffic vs a per-gamma schedule model.
module tb_pulse_width_encoder;

   localparam int G  = 16;
   localparam int PW = 8;
   localparam int VW = $clog2(G);
   localparam int MV = G - 1 - PW;
   localparam int NG = 512;
`ifdef PW_ENC_FALLING_EN
   localparam logic IDLE = 1'b1;
`else
   localparam logic IDLE = 1'b0;
`endif

   typedef struct {
      bit nul;
      int val;
   } item_t;

   logic          aclk = 1'b0;
   logic          grst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_null = 1'b0;
   logic [VW-1:0] in_value = '0;
   logic          in_ready, y, gamma_rst, overflow, underrun;

   int    checks = 0;
   int    errors = 0;
   // Model: which gamma (counted from reset release) shows which accepted value.
   bit    s_vld[NG];
   bit    s_nul[NG];
   int    s_val[NG];
   int    t;
   bit    ovf_flag;
   item_t sendq[$];

   always #5 aclk = ~aclk;

   pulse_width_encoder #(
      .GAMMA_CYCLE_WIDTH(G),
      .PULSE_WIDTH      (PW)
   ) dut (
      .aclk     (aclk),
      .grst     (grst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_value (in_value),
      .in_null  (in_null),
      .y        (y),
      .gamma_rst(gamma_rst),
      .overflow (overflow),
      .underrun (underrun)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NG; i++) begin
         s_vld[i] = 1'b0;
         s_nul[i] = 1'b0;
         s_val[i] = 0;
      end
      t        = 0;
      ovf_flag = 1'b0;
   endtask

   function automatic bit active(input int tt);
      int g = tt / G;
      int c = tt % G;
      return s_vld[g] && !s_nul[g] && (c >= s_val[g] + 1) && (c <= s_val[g] + PW);
   endfunction

   // Entered just after a falling edge with grst low; leaves one cycle later.
   task automatic step();
      int  g, c, k;
      bit  rdy, acc;
      #1;
      g = t / G;
      c = t % G;
      chk("y", y, active(t) ^ IDLE);
      chk("gamma_rst", gamma_rst, c == 0);
      chk("overflow", overflow, ovf_flag);
      chk("underrun", underrun, (c == 0) && (g >= 2) && !s_vld[g]);
      rdy = !s_vld[g + 1] || (c == G - 1);
      chk("in_ready", in_ready, rdy);

      in_valid = (sendq.size() > 0);
      if (in_valid) begin
         in_null  = sendq[0].nul;
         in_value = VW'(sendq[0].val);
      end else begin
         in_null  = 1'($urandom_range(0, 1));
         in_value = VW'($urandom_range(0, G - 1));
      end
      acc      = in_valid && rdy;
      ovf_flag = 1'b0;
      if (acc) begin
         k = g + 1;
         while (s_vld[k]) k++;
         s_vld[k] = 1'b1;
         s_nul[k] = sendq[0].nul;
         s_val[k] = sendq[0].nul ? 0 : ((sendq[0].val > MV) ? MV : sendq[0].val);
         ovf_flag = !sendq[0].nul && (sendq[0].val > MV);
         void'(sendq.pop_front());
      end
      @(posedge aclk);
      @(negedge aclk);
      t++;
   endtask

   task automatic push(input bit nul, input int val);
      item_t it;
      it.nul = nul;
      it.val = val;
      sendq.push_back(it);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_y"}, y, IDLE);
      chk({tag, "_gamma_rst"}, gamma_rst, 1'b1);
      chk({tag, "_overflow"}, overflow, 1'b0);
      chk({tag, "_underrun"}, underrun, 1'b0);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
   endtask

   initial begin
      bit found;
      model_clear();

      // Reset state, then idle for three gammas.
      grst = 1'b1;
      repeat (3) @(negedge aclk);
      #1;
      check_reset_outputs("reset");
      grst = 1'b0;
      model_clear();
      run(48);

      // Single value, back-to-back values, clamp, null.
      push(1'b0, 1);
      run(32);
      push(1'b0, 3);
      push(1'b0, 0);
      run(48);
      push(1'b0, 12);
      run(32);
      push(1'b1, 5);
      run(32);

      // Random traffic with gaps, nulls and out-of-range values.
      for (int i = 0; i < 2000; i++) begin
         if (sendq.size() == 0 && $urandom_range(0, 5) == 0) begin
            push($urandom_range(0, 7) == 0, int'($urandom_range(0, G - 1)));
         end
         step();
      end
      sendq.delete();
      run(2 * G);

      // Reset in the middle of a pulse.
      push(1'b0, 1);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if ((t % G == 5) && active(t)) found = 1'b1;
         else step();
      end
      chk("mid_pulse_reached", found, 1'b1);
      grst     = 1'b1;
      in_valid = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge aclk);
      @(negedge aclk);
      sendq.delete();
      grst = 1'b0;
      model_clear();
      run(48);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
